uart_rx: RTL and testbench

8N1 serial receiver that consumes the tx line format produced by the team's uart transmitter: idle high, one start bit, 8 data bits LSB first, one stop bit. It uses the same fixed bit period as the transmitter, 434 clocks (115200 baud at 50 MHz). It samples the rx pin at mid-bit and holds one received byte for the CPU, with sticky framing-error and overrun flags. It sits beside the transmitter on the CPU's I/O bus; its rx input is driven from a pad or, in test, from the transmitter's tx output.

---
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with a single-byte holding register.
//
// Line format: idle high, one start bit (low), 8 data bits LSB first, one
// stop bit (high). The bit period is fixed at BIT_CYCLES clocks, which is the
// same period the companion transmitter uses. The pin is synchronised, then
// sampled once per bit at mid-bit. A received byte is held for the CPU until
// it is acknowledged with re.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   rx     in   serial input (asynchronous to clk, idle high)
//   re     in   one-cycle read strobe; clears valid, ferr and ovr
//   rdata  out  last received byte
//   valid  out  rdata holds an unread byte
//   ferr   out  sticky framing error (a stop bit was sampled low)
//   ovr    out  sticky overrun (an unread byte was overwritten)
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       ferr,
  output logic       ovr
);

  // Start-bit sample happens half a bit after the falling edge is seen, so
  // every later sample lands one full bit period further on, i.e. mid-bit.
  localparam int          HALF_CYCLES = BIT_CYCLES / 2;
  localparam logic [15:0] HALF_LAST   = 16'(HALF_CYCLES - 1);
  localparam logic [15:0] BIT_LAST    = 16'(BIT_CYCLES - 1);
  localparam int          SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Synchroniser. Both stages reset to 1 (idle line) so that releasing reset
  // never looks like a start edge by itself.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // Frame state.
  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;

  // CPU-visible registers.
  logic [7:0]  rdata_reg;
  logic        valid_reg;
  logic        ferr_reg;
  logic        ovr_reg;

  // Sample-point decode for the current state.
  logic half_tick;
  logic bit_tick;

  assign half_tick = (cnt_reg == HALF_LAST);
  assign bit_tick  = (cnt_reg == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 16'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      rdata_reg   <= 8'h00;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      // A read clears the status; a byte load or framing error later in this
      // block overrides the clear, so a load in the same cycle wins.
      if (re) begin
        valid_reg <= 1'b0;
        ferr_reg  <= 1'b0;
        ovr_reg   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg     <= 16'd0;
          bit_idx_reg <= 3'd0;
          if (!rx_s) begin
            state_reg <= START;
          end
        end

        START: begin
          if (half_tick) begin
            cnt_reg <= 16'd0;
            if (!rx_s) begin
              state_reg   <= DATA;
              bit_idx_reg <= 3'd0;
            end else begin
              // Line went high again before mid start bit: a glitch, not a
              // frame. Nothing visible changes.
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            cnt_reg   <= 16'd0;
            // LSB arrives first; after eight shifts bit k sits in shift[k].
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        STOP: begin
          if (bit_tick) begin
            cnt_reg <= 16'd0;
            if (rx_s) begin
              rdata_reg <= shift_reg;
              valid_reg <= 1'b1;
              // An unread byte is lost unless the CPU reads it this cycle.
              if (valid_reg && !re) begin
                ovr_reg <= 1'b1;
              end
              // Returning to IDLE mid stop bit leaves half a bit of margin
              // to catch a start bit that follows without an idle gap.
              state_reg <= IDLE;
            end else begin
              ferr_reg  <= 1'b1;
              state_reg <= BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        BREAK: begin
          // Wait for the line to return high so a held-low line yields one
          // framing error rather than a stream of bogus frames. The counter
          // keeps running but wraps inside one bit period.
          if (rx_s) begin
            state_reg <= IDLE;
            cnt_reg   <= 16'd0;
          end else if (bit_tick) begin
            cnt_reg <= 16'd0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 16'd0;
        end
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign valid = valid_reg;
  assign ferr  = ferr_reg;
  assign ovr   = ovr_reg;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = BIT / 2;
  // Pin edge to visible valid: 2 synchroniser edges + the edge entering
  // START, then HALF + 9*BIT edges to the stop sample.
  localparam int LOAD_EDGES = 3 + HALF + 9 * BIT;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       re;
  logic       re_dir;
  logic       re_mon;
  logic [7:0] rdata;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int         checks = 0;
  int         errors = 0;
  bit         auto_read = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         ferr_rises = 0;
  logic       ferr_q;

  assign re = re_dir | re_mon;

  uart_rx #(.BIT_CYCLES(BIT)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .re    (re),
    .rdata (rdata),
    .valid (valid),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at the current negedge. stop_bits > 1 with a
  // low stop level models a held-low (break) line.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                            input int stop_bits, input bit push);
    if (push) exp_q.push_back(d);
    $display("TX byte %02h stop %0d", d, stop_lvl);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (BIT * stop_bits) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_re();
    re_dir = 1'b1;
    @(negedge clk);
    re_dir = 1'b0;
  endtask

  // Counts framing-error events.
  initial begin
    ferr_q = 1'b0;
    forever begin
      @(negedge clk);
      if (ferr && !ferr_q) ferr_rises++;
      ferr_q = ferr;
    end
  end

  // Scoreboard monitor: in auto mode, every presented byte is popped against
  // the expected queue and then acknowledged.
  initial begin
    re_mon = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_read && !reset && valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none", rdata);
        end else begin
          exp_b = exp_q.pop_front();
          $display("RX byte %02h expected %02h", rdata, exp_b);
          check("rx_data", 32'(rdata), 32'(exp_b));
          check("rx_ferr", 32'(ferr), 32'd0);
          check("rx_ovr", 32'(ovr), 32'd0);
        end
        re_mon = 1'b1;
        @(negedge clk);
        re_mon = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    logic [7:0] d81;
    reset  = 1'b1;
    rx     = 1'b1;
    re_dir = 1'b0;
    d81    = 8'h81;
    repeat (3) @(negedge clk);
    check("reset_rdata", 32'(rdata), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_ovr", 32'(ovr), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with latency measurement.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1, 1'b0);
      begin
        while (lat < 1000) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (valid) break;
        end
      end
    join
    check("single_latency", 32'(lat), 32'(LOAD_EDGES));
    check("single_data", 32'(rdata), 32'hA5);
    check("single_ferr", 32'(ferr), 32'd0);
    check("single_ovr", 32'(ovr), 32'd0);
    pulse_re();
    check("single_read_valid", 32'(valid), 32'd0);
    check("single_read_rdata", 32'(rdata), 32'hA5);

    // Glitch: short low pulse must not start a frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_ferr", 32'(ferr), 32'd0);
    check("glitch_ovr", 32'(ovr), 32'd0);

    // Framing error followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, 40, 1'b0);
    check("break_ferr", 32'(ferr), 32'd1);
    check("break_valid", 32'(valid), 32'd0);
    check("break_ovr", 32'(ovr), 32'd0);
    check("break_one_error", 32'(ferr_rises), 32'd1);
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h12, 1'b1, 1, 1'b0);
    check("after_break_valid", 32'(valid), 32'd1);
    check("after_break_data", 32'(rdata), 32'h12);
    check("after_break_ferr_sticky", 32'(ferr), 32'd1);
    check("after_break_one_error", 32'(ferr_rises), 32'd1);
    pulse_re();
    check("after_break_clr_ferr", 32'(ferr), 32'd0);
    check("after_break_clr_valid", 32'(valid), 32'd0);

    // Overrun: two back-to-back bytes, no read.
    send_frame(8'h11, 1'b1, 1, 1'b0);
    check("ovr_first_data", 32'(rdata), 32'h11);
    check("ovr_first_ovr", 32'(ovr), 32'd0);
    send_frame(8'h22, 1'b1, 1, 1'b0);
    check("ovr_data", 32'(rdata), 32'h22);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_flag", 32'(ovr), 32'd1);
    check("ovr_ferr", 32'(ferr), 32'd0);
    pulse_re();
    check("ovr_read_valid", 32'(valid), 32'd0);
    check("ovr_read_flag", 32'(ovr), 32'd0);

    // Read strobe on the exact load cycle of the second byte.
    send_frame(8'h33, 1'b1, 1, 1'b0);
    fork
      send_frame(8'h44, 1'b1, 1, 1'b0);
      begin
        repeat (LOAD_EDGES - 1) @(negedge clk);
        check("simul_pre_valid", 32'(valid), 32'd1);
        check("simul_pre_data", 32'(rdata), 32'h33);
        re_dir = 1'b1;
        @(negedge clk);
        re_dir = 1'b0;
      end
    join
    check("simul_valid", 32'(valid), 32'd1);
    check("simul_ovr", 32'(ovr), 32'd0);
    check("simul_data", 32'(rdata), 32'h44);
    pulse_re();

    // Reset during data bit 4 of 0x81 with an unread byte held.
    send_frame(8'h5A, 1'b1, 1, 1'b0);
    check("pre_reset_valid", 32'(valid), 32'd1);
    $display("TX byte %02h aborted by reset", d81);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d81[i];
      repeat (BIT) @(negedge clk);
    end
    rx = d81[4];
    repeat (HALF) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rdata", 32'(rdata), 32'h00);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_ferr", 32'(ferr), 32'd0);
    check("midreset_ovr", 32'(ovr), 32'd0);
    repeat (BIT - HALF - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = d81[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("post_reset_valid", 32'(valid), 32'd0);

    // Scoreboarded traffic: 0x7E, back-to-back 0x00/0xFF/0x55, then random.
    auto_read = 1'b1;
    send_frame(8'h7E, 1'b1, 1, 1'b1);
    repeat (BIT) @(negedge clk);
    send_frame(8'h00, 1'b1, 1, 1'b1);
    send_frame(8'hFF, 1'b1, 1, 1'b1);
    send_frame(8'h55, 1'b1, 1, 1'b1);
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1, 1'b1);
      repeat (BIT * int'($urandom_range(0, 3))) @(negedge clk);
    end
    for (int i = 0; i < 30 * BIT && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("final_ferr", 32'(ferr), 32'd0);
    check("final_ovr", 32'(ovr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
